// File: rtl/led_bias_pkg.sv
// Shared types and sizing helpers for the LED bias sequencer.
package led_bias_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2,
    ST_DRAIN  = 2'd3
  } dom_state_e;

  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_OFF_HOLD      = 16;

  // Width of the settle/hold down-counter, large enough for the longer reload.
  function automatic int unsigned dom_cnt_w(input int unsigned settle, input int unsigned hold);
    int unsigned m;
    m = (settle > hold) ? settle : hold;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_dom_fsm.sv
// One bias domain: OFF/SETTLE/ON/DRAIN sequencing, settle/hold timer and PWM gate.
module led_dom_fsm
  import led_bias_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned OFF_HOLD      = DEF_OFF_HOLD
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic wrap,
  output logic en,
  output logic active,
  output logic active_next_c
);

  localparam int unsigned CW = dom_cnt_w(SETTLE_CYCLES, OFF_HOLD);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(OFF_HOLD - 1);

  dom_state_e    state;
  logic [CW-1:0] cnt;

  // PWM gate only opens on a wrap seen while already in ON, and closes as soon as req drops.
  assign active_next_c = (state == ST_ON) && req && (active || wrap);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_OFF;
      cnt    <= '0;
      en     <= 1'b0;
      active <= 1'b0;
    end else begin
      active <= active_next_c;
      unique case (state)
        ST_OFF: begin
          if (req) begin
            state <= ST_SETTLE;
            en    <= 1'b1;
            cnt   <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (!req) begin
            state <= ST_OFF;
            en    <= 1'b0;
          end else if (cnt == '0) begin
            state <= ST_ON;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ON: begin
          if (!req) begin
            state <= ST_DRAIN;
            cnt   <= HOLD_LOAD;
          end
        end
        ST_DRAIN: begin
          // Requests are ignored until the drain hold has fully elapsed.
          if (cnt == '0) begin
            if (req) begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LOAD;
            end else begin
              state <= ST_OFF;
              en    <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: rtl/led_bias_seq.sv
// LED bias enable sequencer with shared-counter, shadowed-duty PWM for RGB and IR channels.
module led_bias_seq
  import led_bias_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned OFF_HOLD      = DEF_OFF_HOLD,
  parameter int unsigned PWM_W         = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rgb_req,
  input  logic               ir_req,
  input  logic               pwm_tick,
  input  logic [3*PWM_W-1:0] rgb_duty,
  input  logic [PWM_W-1:0]   ir_duty,
  output logic               rgbled_en,
  output logic               irled_en,
  output logic [2:0]         rgb_pwm,
  output logic               ir_pwm,
  output logic               rgb_ready,
  output logic               ir_ready
);

  localparam int unsigned NCH = 4;

  logic                      wrap;
  logic                      rgb_act_next;
  logic                      ir_act_next;
  logic [PWM_W-1:0]          ctr;
  logic [PWM_W-1:0]          ctr_next;
  logic [NCH-1:0][PWM_W-1:0] shadow;
  logic [NCH-1:0][PWM_W-1:0] shadow_next;
  logic [NCH-1:0]            pwm_q;
  logic [NCH-1:0]            pwm_next;

  assign wrap = pwm_tick && (ctr == '1);

  led_dom_fsm #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .OFF_HOLD     (OFF_HOLD)
  ) u_rgb_fsm (
    .clk          (clk),
    .resetn       (resetn),
    .req          (rgb_req),
    .wrap         (wrap),
    .en           (rgbled_en),
    .active       (rgb_ready),
    .active_next_c(rgb_act_next)
  );

  led_dom_fsm #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .OFF_HOLD     (OFF_HOLD)
  ) u_ir_fsm (
    .clk          (clk),
    .resetn       (resetn),
    .req          (ir_req),
    .wrap         (wrap),
    .en           (irled_en),
    .active       (ir_ready),
    .active_next_c(ir_act_next)
  );

  // Next counter/shadow values; duties are only sampled at the period boundary.
  always_comb begin
    ctr_next    = pwm_tick ? ctr + PWM_W'(1) : ctr;
    shadow_next = shadow;
    if (wrap) begin
      shadow_next = {ir_duty, rgb_duty};
    end
  end

  // Compare against next-state values so the flopped output tracks the counter exactly.
  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < 3; i++) begin
      pwm_next[i] = rgb_act_next && (ctr_next < shadow_next[i]);
    end
    pwm_next[3] = ir_act_next && (ctr_next < shadow_next[3]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctr    <= '0;
      shadow <= '0;
      pwm_q  <= '0;
    end else begin
      ctr    <= ctr_next;
      shadow <= shadow_next;
      pwm_q  <= pwm_next;
    end
  end

  assign rgb_pwm = pwm_q[2:0];
  assign ir_pwm  = pwm_q[3];

endmodule

// File: tb/tb_led_bias_seq.sv
// Bench for led_bias_seq: directed scenarios plus randomized traffic against a time-based reference model.
module tb_led_bias_seq;

  localparam int SETTLE = 8;
  localparam int HOLD   = 16;
  localparam int W      = 8;
  localparam int PERIOD = 1 << W;

  localparam int P_OFF    = 0;
  localparam int P_SETTLE = 1;
  localparam int P_ON     = 2;
  localparam int P_DRAIN  = 3;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           rgb_req = 1'b0;
  logic           ir_req = 1'b0;
  logic           pwm_tick = 1'b0;
  logic [3*W-1:0] rgb_duty = '0;
  logic [W-1:0]   ir_duty = '0;
  logic           rgbled_en;
  logic           irled_en;
  logic [2:0]     rgb_pwm;
  logic           ir_pwm;
  logic           rgb_ready;
  logic           ir_ready;

  led_bias_seq #(
    .SETTLE_CYCLES(SETTLE),
    .OFF_HOLD     (HOLD),
    .PWM_W        (W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rgb_req  (rgb_req),
    .ir_req   (ir_req),
    .pwm_tick (pwm_tick),
    .rgb_duty (rgb_duty),
    .ir_duty  (ir_duty),
    .rgbled_en(rgbled_en),
    .irled_en (irled_en),
    .rgb_pwm  (rgb_pwm),
    .ir_pwm   (ir_pwm),
    .rgb_ready(rgb_ready),
    .ir_ready (ir_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase per domain plus the absolute cycle at which it was entered.
  int m_ctr;
  int m_sh[4];
  int m_ph[2];
  int m_t0[2];
  bit m_act[2];
  int cyc;

  bit rnd = 1'b0;
  int dw[2];
  int hi[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ctr = 0;
    cyc   = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 0;
    for (int d = 0; d < 2; d++) begin
      m_ph[d]  = P_OFF;
      m_t0[d]  = 0;
      m_act[d] = 1'b0;
    end
  endtask

  task automatic m_step();
    bit wrap;
    bit rq[2];
    if (!resetn) begin
      m_reset();
      return;
    end
    wrap  = pwm_tick && (m_ctr == PERIOD - 1);
    rq[0] = rgb_req;
    rq[1] = ir_req;
    for (int d = 0; d < 2; d++) begin
      case (m_ph[d])
        P_OFF: if (rq[d]) begin m_ph[d] = P_SETTLE; m_t0[d] = cyc + 1; end
        P_SETTLE: begin
          if (!rq[d]) m_ph[d] = P_OFF;
          else if (cyc + 1 - m_t0[d] >= SETTLE) begin m_ph[d] = P_ON; m_t0[d] = cyc + 1; end
        end
        P_ON: begin
          if (!rq[d]) begin m_ph[d] = P_DRAIN; m_t0[d] = cyc + 1; m_act[d] = 1'b0; end
          else if (wrap) m_act[d] = 1'b1;
        end
        default: begin
          if (cyc + 1 - m_t0[d] >= HOLD) begin
            m_ph[d] = rq[d] ? P_SETTLE : P_OFF;
            m_t0[d] = cyc + 1;
          end
        end
      endcase
    end
    if (wrap) begin
      for (int i = 0; i < 3; i++) m_sh[i] = int'(rgb_duty[i*W +: W]);
      m_sh[3] = int'(ir_duty);
    end
    if (pwm_tick) m_ctr = (m_ctr + 1) % PERIOD;
    cyc++;
  endtask

  task automatic check_outputs();
    logic [2:0] erp;
    for (int i = 0; i < 3; i++) erp[i] = m_act[0] && (m_ctr < m_sh[i]);
    check("rgbled_en", 32'(rgbled_en), 32'(m_ph[0] != P_OFF));
    check("irled_en",  32'(irled_en),  32'(m_ph[1] != P_OFF));
    check("rgb_pwm",   32'(rgb_pwm),   32'(erp));
    check("ir_pwm",    32'(ir_pwm),    32'(m_act[1] && (m_ctr < m_sh[3])));
    check("rgb_ready", 32'(rgb_ready), 32'(m_act[0]));
    check("ir_ready",  32'(ir_ready),  32'(m_act[1]));
  endtask

  task automatic clear_hi();
    for (int i = 0; i < 8; i++) hi[i] = 0;
  endtask

  // One clock per iteration: model the coming edge, then compare at the falling edge.
  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        pwm_tick = ($urandom_range(0, 3) != 0);
        for (int d = 0; d < 2; d++) begin
          if (dw[d] == 0) begin
            if (d == 0) rgb_req = ~rgb_req; else ir_req = ~ir_req;
            dw[d] = int'($urandom_range(1, 700));
          end else begin
            dw[d]--;
          end
        end
        if ($urandom_range(0, 63) == 0) rgb_duty = 24'($urandom);
        if ($urandom_range(0, 63) == 0) ir_duty = 8'($urandom);
      end
      m_step();
      @(negedge clk);
      check_outputs();
      for (int i = 0; i < 3; i++) hi[i] += int'(rgb_pwm[i]);
      hi[3] += int'(ir_pwm);
      hi[4] += int'(rgbled_en);
      hi[5] += int'(irled_en);
      hi[6] += int'(rgb_ready);
      hi[7] += int'(ir_ready);
    end
  endtask

  initial begin
    int w;
    @(negedge clk);
    m_reset();
    check_outputs();
    advance(3);

    // Idle after reset release
    resetn   = 1'b1;
    pwm_tick = 1'b1;
    clear_hi();
    advance(1000);
    check("idle_en_cycles", 32'(hi[4] + hi[5]), 32'd0);

    // RGB bring-up with R=64, G=32, B=0
    rgb_duty = {8'd0, 8'd32, 8'd64};
    rgb_req  = 1'b1;
    advance(1);
    check("rgb_en_latency", 32'(rgbled_en), 32'd1);
    w = 0;
    clear_hi();
    while (!rgb_ready && w < 600) begin
      clear_hi();
      advance(1);
      w++;
    end
    check("rgb_ready_seen", 32'(rgb_ready), 32'd1);
    advance(99);
    rgb_duty = {8'd255, 8'd200, 8'd64};
    advance(156);
    check("r_high_per_period", 32'(hi[0]), 32'd64);
    check("g_high_old_duty",   32'(hi[1]), 32'd32);
    check("b_duty0_low",       32'(hi[2]), 32'd0);
    clear_hi();
    advance(256);
    check("g_high_new_duty",   32'(hi[1]), 32'd200);
    check("b_duty255_high",    32'(hi[2]), 32'd255);

    // IR short pulse inside settle
    clear_hi();
    ir_req = 1'b1;
    advance(4);
    ir_req = 1'b0;
    advance(20);
    check("ir_pulse_en_cycles", 32'(hi[5]), 32'd4);
    check("ir_pulse_pwm",       32'(hi[3]), 32'd0);
    check("ir_pulse_ready",     32'(hi[7]), 32'd0);

    // RGB drop in ON, then re-request during drain
    clear_hi();
    rgb_req = 1'b0;
    advance(1);
    check("rgb_ready_drop", 32'(rgb_ready), 32'd0);
    check("rgb_pwm_drop",   32'(rgb_pwm),   32'd0);
    advance(29);
    check("rgb_drain_en_cycles", 32'(hi[4]), 32'd16);
    rgb_req = 1'b1;
    advance(12);
    rgb_req = 1'b0;
    advance(5);
    rgb_req = 1'b1;
    clear_hi();
    advance(40);
    check("rgb_rereq_no_gap", 32'(hi[4]), 32'd40);

    // Async reset with RGB in ON and IR in DRAIN
    ir_req = 1'b1;
    advance(12);
    ir_req = 1'b0;
    advance(3);
    ir_req = 1'b1;
    resetn = 1'b0;
    #1;
    check("arst_outputs", 32'({rgbled_en, irled_en, rgb_pwm, ir_pwm, rgb_ready, ir_ready}), 32'd0);
    advance(3);
    resetn = 1'b1;
    advance(1);
    check("restart_rgb_en", 32'(rgbled_en), 32'd1);
    check("restart_ir_en",  32'(irled_en),  32'd1);
    advance(20);

    // Randomized traffic
    dw[0] = int'($urandom_range(1, 700));
    dw[1] = int'($urandom_range(1, 700));
    rnd   = 1'b1;
    advance(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
